aes_frame_ctrl: RTL
===================

// Module: aes_frame_ctrl
// PURPOSE
// - Sequencing controller between the SPI frame slave and a multi-cycle AES core.
// - Accepts received frames, validates key length and opcode, and launches one core operation per frame.
// - Supports encrypt and decrypt, with 128, 192 and 256-bit keys.
// - Buffers one pending frame, handles core timeouts, and loads the result plus a status byte into the slave's next response frame.
// PARAMETERS
// - BLOCK_W  128  data block width (bits)
// - KEY_W    256  maximum key field width; shorter keys are left-aligned (MSB first)
// - FRAME_W  BLOCK_W+16+KEY_W  frame width; layout (MSB->LSB): block | keylen byte | opcode byte | key
// - TMO_W    10   timeout counter width; the core gets at most 2**TMO_W-1 cycles
// PORTS
// - clk          in   1        clock
// - reset        in   1        synchronous, active-high reset
// - rx_valid     in   1        1-cycle pulse: rx_frame holds a complete received frame
// - rx_frame     in   FRAME_W  received frame
// - tx_frame     out  FRAME_W  response frame to the slave: result | status | zeros
// - tx_load      out  1        1-cycle pulse: tx_frame has been updated
// - core_start   out  1        1-cycle pulse: launch the core
// - core_decrypt out  1        0 = encrypt, 1 = decrypt
// - core_nk      out  4        key length in 32-bit words: 4, 6 or 8
// - core_key     out  KEY_W    key, left-aligned
// - core_block   out  BLOCK_W  input block
// - core_done    in   1        1-cycle pulse: core_result is valid
// - core_result  in   BLOCK_W  core output block
// - busy         out  1        high in every state except IDLE
// - overflow     out  1        sticky: a frame was dropped; cleared only by reset
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE; pending buffer empty.
// - Field decode:
//   - keylen byte must be 16, 24 or 32 (giving nk = 4, 6, 8).
//   - opcode byte must be 0x00 (enc) or 0x01 (dec).
//   - Any other value is BAD.
// - FSM:
//   - IDLE: on rx_valid, capture the frame into the working register -> DECODE.
//   - DECODE (1 cycle):
//     - BAD -> RESP with status 0x01 (bad keylen) or 0x02 (bad opcode); keylen is checked first.
//     - Otherwise -> START.
//   - START: pulse core_start for 1 cycle; core_* stay stable until WAIT exits; clear the timeout counter -> WAIT.
//   - WAIT: increment the timeout counter every cycle.
//     - core_done -> latch core_result, status 0x00 -> RESP.
//     - Counter saturates at max -> result 0, status 0x04 -> RESP.
//   - RESP: drive tx_frame = {result, status, 0}; pulse tx_load.
//     - If the pending buffer is full, move it into the working register and empty it -> DECODE.
//     - Otherwise -> IDLE.
// - Latency, valid frame: rx_valid at cycle t -> core_start at t+2; tx_load 1 cycle after core_done.
// - Latency, BAD frame: rx_valid at t -> tx_load at t+2; the core is never started.
// - Pending buffer (depth 1):
//   - rx_valid while busy and buffer empty: store the frame.
//   - rx_valid while busy and buffer full: drop the new frame, set overflow; the existing buffer is kept.
// - Simultaneous events:
//   - rx_valid in the same cycle as RESP: the RESP drain happens first, then the new frame goes into the just-emptied buffer. No frame is lost.
//   - core_done in the same cycle as timeout saturation: core_done wins and status is 0x00.
// - core_done outside WAIT is ignored.
// - tx_frame holds its value between tx_load pulses.
// - Reset mid-operation:
//   - Return to IDLE immediately and empty the buffer.
//   - No tx_load is issued.
//   - A later stray core_done is ignored.
// STRUCTURE
// - Shared package aes_pkg: status codes (ST_OK, ST_BAD_KEYLEN, ST_BAD_OP, ST_TIMEOUT), opcode constants, keylen-to-nk function, frame field offset localparams.
// - Sub-module aes_frame_decode: combinational field extraction and validation (block, key, nk, decrypt, status); instantiated once on the working register.
// - FSM, timeout counter and pending buffer stay in this module.
// TESTING
// - FIPS-197 C.1 encrypt: block 00112233..eeff, key 000102..0f, keylen 16, op 0 -> core_nk=4, core_start at t+2; model core returns 69c4e0d8..c55a -> tx_frame MSBs 69c4e0d8..c55a, status 0x00.
// - Decrypt with keylen 32 (key 000102..1f), op 1 -> core_decrypt=1, core_nk=8, core_key=full 256 bits, status 0x00.
// - keylen 20 -> no core_start; status 0x01 at t+2. keylen 24 with op 0x07 -> status 0x02.
// - Core never asserts done -> tx_load after 2**TMO_W-1 WAIT cycles, result 0, status 0x04; next frame is processed normally.
// - Three back-to-back rx_valid while busy -> first processed, second buffered and processed with no idle cycle, third dropped; overflow=1.
// - reset asserted during WAIT, then stray core_done -> outputs 0, no tx_load, state IDLE; buffer empty.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types, status codes and field helpers for the AES frame controller
package aes_pkg;

  localparam int DEF_BLOCK_W = 128;
  localparam int DEF_KEY_W   = 256;
  localparam int DEF_TMO_W   = 10;

  localparam int FIELD_W = 8;
  localparam int HDR_W   = 2 * FIELD_W;

  // Header field positions, measured from the top bit of the key field
  localparam int OFS_OPCODE = 0;
  localparam int OFS_KEYLEN = FIELD_W;
  localparam int OFS_BLOCK  = HDR_W;

  localparam logic [7:0] ST_OK         = 8'h00;
  localparam logic [7:0] ST_BAD_KEYLEN = 8'h01;
  localparam logic [7:0] ST_BAD_OP     = 8'h02;
  localparam logic [7:0] ST_TIMEOUT    = 8'h04;

  localparam logic [7:0] OP_ENC = 8'h00;
  localparam logic [7:0] OP_DEC = 8'h01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  // Zero marks an unsupported key length
  function automatic logic [3:0] keylen_to_nk(input logic [7:0] keylen);
    case (keylen)
      8'd16:   keylen_to_nk = 4'd4;
      8'd24:   keylen_to_nk = 4'd6;
      8'd32:   keylen_to_nk = 4'd8;
      default: keylen_to_nk = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/aes_frame_ctrl_if.sv
// rtl/aes_frame_ctrl_if.sv - frame slave and AES core signals seen by the frame controller
interface aes_frame_ctrl_if #(
  parameter int BLOCK_W = aes_pkg::DEF_BLOCK_W,
  parameter int KEY_W   = aes_pkg::DEF_KEY_W
);
  localparam int FRAME_W = BLOCK_W + aes_pkg::HDR_W + KEY_W;

  logic               rx_valid;
  logic [FRAME_W-1:0] rx_frame;
  logic [FRAME_W-1:0] tx_frame;
  logic               tx_load;
  logic               core_start;
  logic               core_decrypt;
  logic [3:0]         core_nk;
  logic [KEY_W-1:0]   core_key;
  logic [BLOCK_W-1:0] core_block;
  logic               core_done;
  logic [BLOCK_W-1:0] core_result;
  logic               busy;
  logic               overflow;

  modport master (
    input  rx_valid, rx_frame, core_done, core_result,
    output tx_frame, tx_load, core_start, core_decrypt, core_nk, core_key,
           core_block, busy, overflow
  );

  modport slave (
    output rx_valid, rx_frame, core_done, core_result,
    input  tx_frame, tx_load, core_start, core_decrypt, core_nk, core_key,
           core_block, busy, overflow
  );

endinterface

// File: rtl/aes_frame_decode.sv
// rtl/aes_frame_decode.sv - combinational field extraction and validation of one frame
module aes_frame_decode
  import aes_pkg::*;
#(
  parameter int BLOCK_W = DEF_BLOCK_W,
  parameter int KEY_W   = DEF_KEY_W
) (
  input  logic [BLOCK_W+HDR_W+KEY_W-1:0] i_frame,
  output logic [BLOCK_W-1:0]             o_block,
  output logic [KEY_W-1:0]               o_key,
  output logic [3:0]                     o_nk,
  output logic                           o_decrypt,
  output logic [7:0]                     o_status
);

  logic [FIELD_W-1:0] w_keylen;
  logic [FIELD_W-1:0] w_opcode;

  assign o_key     = i_frame[KEY_W-1:0];
  assign w_opcode  = i_frame[KEY_W+OFS_OPCODE +: FIELD_W];
  assign w_keylen  = i_frame[KEY_W+OFS_KEYLEN +: FIELD_W];
  assign o_block   = i_frame[KEY_W+OFS_BLOCK +: BLOCK_W];
  assign o_nk      = keylen_to_nk(w_keylen);
  assign o_decrypt = (w_opcode == OP_DEC);

  // A bad key length hides a bad opcode
  always_comb begin
    o_status = ST_OK;
    if (o_nk == 4'd0) begin
      o_status = ST_BAD_KEYLEN;
    end else if ((w_opcode != OP_ENC) && (w_opcode != OP_DEC)) begin
      o_status = ST_BAD_OP;
    end
  end

endmodule

// File: rtl/aes_frame_ctrl.sv
// rtl/aes_frame_ctrl.sv - sequences received frames through a multi-cycle AES core
module aes_frame_ctrl
  import aes_pkg::*;
#(
  parameter int BLOCK_W = DEF_BLOCK_W,
  parameter int KEY_W   = DEF_KEY_W,
  parameter int TMO_W   = DEF_TMO_W
) (
  input logic              clk,
  input logic              reset,
  aes_frame_ctrl_if.master bus
);

  localparam int FRAME_W = BLOCK_W + HDR_W + KEY_W;
  localparam int PAD_W   = FRAME_W - BLOCK_W - FIELD_W;
  // Last WAIT cycle: the counter reaches its maximum as WAIT is left
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t             r_state;
  state_t             w_state_nxt;
  logic [FRAME_W-1:0] r_work;
  logic [FRAME_W-1:0] r_pend;
  logic               r_pend_full;
  logic               r_overflow;
  logic [TMO_W-1:0]   r_tmo;
  logic [FRAME_W-1:0] r_tx_frame;

  logic               w_take_rx;
  logic               w_take_pend;
  logic               w_resp_en;
  logic [BLOCK_W-1:0] w_resp_result;
  logic [7:0]         w_resp_status;
  logic               w_tmo_sat;

  logic [BLOCK_W-1:0] w_dec_block;
  logic [KEY_W-1:0]   w_dec_key;
  logic [3:0]         w_dec_nk;
  logic               w_dec_decrypt;
  logic [7:0]         w_dec_status;

  aes_frame_decode #(
    .BLOCK_W (BLOCK_W),
    .KEY_W   (KEY_W)
  ) u_decode (
    .i_frame   (r_work),
    .o_block   (w_dec_block),
    .o_key     (w_dec_key),
    .o_nk      (w_dec_nk),
    .o_decrypt (w_dec_decrypt),
    .o_status  (w_dec_status)
  );

  assign w_tmo_sat = (r_tmo == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_take_rx     = 1'b0;
    w_take_pend   = 1'b0;
    w_resp_en     = 1'b0;
    w_resp_result = '0;
    w_resp_status = ST_OK;
    case (r_state)
      S_IDLE: begin
        if (bus.rx_valid) begin
          w_take_rx   = 1'b1;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_dec_status != ST_OK) begin
          w_resp_en     = 1'b1;
          w_resp_status = w_dec_status;
          w_state_nxt   = S_RESP;
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.core_done) begin
          w_resp_en     = 1'b1;
          w_resp_result = bus.core_result;
          w_state_nxt   = S_RESP;
        end else if (w_tmo_sat) begin
          w_resp_en     = 1'b1;
          w_resp_status = ST_TIMEOUT;
          w_state_nxt   = S_RESP;
        end
      end
      S_RESP: begin
        // Buffered frame goes first; a frame arriving now goes straight to work if nothing waits
        if (r_pend_full) begin
          w_take_pend = 1'b1;
          w_state_nxt = S_DECODE;
        end else if (bus.rx_valid) begin
          w_take_rx   = 1'b1;
          w_state_nxt = S_DECODE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_work      <= '0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_overflow  <= 1'b0;
      r_tmo       <= '0;
      r_tx_frame  <= '0;
    end else begin
      if (w_take_rx) begin
        r_work <= bus.rx_frame;
      end else if (w_take_pend) begin
        r_work <= r_pend;
      end

      // Drain and refill in the same RESP cycle keeps the buffer occupied
      if (r_state == S_RESP) begin
        if (r_pend_full) begin
          r_pend_full <= bus.rx_valid;
          if (bus.rx_valid) begin
            r_pend <= bus.rx_frame;
          end
        end
      end else if ((r_state != S_IDLE) && bus.rx_valid) begin
        if (!r_pend_full) begin
          r_pend      <= bus.rx_frame;
          r_pend_full <= 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
      end

      if (r_state == S_START) begin
        r_tmo <= '0;
      end else if (r_state == S_WAIT) begin
        r_tmo <= r_tmo + TMO_W'(1);
      end

      if (w_resp_en) begin
        r_tx_frame <= {w_resp_result, w_resp_status, {PAD_W{1'b0}}};
      end
    end
  end

  assign bus.tx_frame     = r_tx_frame;
  assign bus.tx_load      = (r_state == S_RESP);
  assign bus.core_start   = (r_state == S_START);
  assign bus.core_decrypt = w_dec_decrypt;
  assign bus.core_nk      = w_dec_nk;
  assign bus.core_key     = w_dec_key;
  assign bus.core_block   = w_dec_block;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.overflow     = r_overflow;

endmodule
